// File: rtl/frame_buffer_ctrl_if.sv
// Pixel-capture and output-FIFO signal bundle for frame_buffer_ctrl.
// slave is the controller side, master is the capture/display side.
interface frame_buffer_ctrl_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  i_valid;
  logic                  i_sof;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_wr;
  logic [DATA_WIDTH-1:0] o_wdata;
  logic                  i_almostfull;
  logic                  i_req;
  logic [1:0]            o_full;
  logic                  o_rbank;
  logic                  o_frame_drop;

  modport slave (
    input  i_valid, i_sof, i_data, i_almostfull, i_req,
    output o_wr, o_wdata, o_full, o_rbank, o_frame_drop
  );

  modport master (
    output i_valid, i_sof, i_data, i_almostfull, i_req,
    input  o_wr, o_wdata, o_full, o_rbank, o_frame_drop
  );
endinterface

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered frame store: camera pixels fill one BRAM bank while the other
// streams to the display FIFO; banks change hands only at frame boundaries.
module frame_buffer_ctrl #(
  parameter int DATA_WIDTH   = 12,
  parameter int FRAME_PIXELS = 307200
) (
  input logic           i_clk,
  input logic           i_rst,
  frame_buffer_ctrl_if.slave bus
);
  localparam int AW  = $clog2(FRAME_PIXELS);
  localparam int PAW = $clog2(2 * FRAME_PIXELS);
  localparam logic [AW-1:0] LAST = AW'(FRAME_PIXELS - 1);

  typedef enum logic {W_IDLE, W_ACTIVE} wstate_t;
  typedef enum logic {R_IDLE, R_ACTIVE} rstate_t;

  wstate_t               wstate;
  rstate_t               rstate;
  logic [AW-1:0]         waddr, raddr, wr_laddr;
  logic                  wbank, rbank;
  logic [1:0]            full;
  logic                  wr_en, w_last, w_drop, rd_issue, rd_last;
  logic [1:0]            set_mask, clr_mask;
  logic                  drop_q;
  logic                  rd_vld_p1;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  wr_p2;
  logic [DATA_WIDTH-1:0] wdata_p2;
  logic [DATA_WIDTH-1:0] mem [0:2*FRAME_PIXELS-1];

  function automatic logic [PAW-1:0] phys_addr(input logic bank, input logic [AW-1:0] laddr);
    return (bank ? PAW'(FRAME_PIXELS) : '0) + PAW'(laddr);
  endfunction

  always_comb begin
    wr_en    = 1'b0;
    wr_laddr = waddr;
    w_last   = 1'b0;
    w_drop   = 1'b0;
    if (!i_rst && bus.i_valid) begin
      case (wstate)
        W_IDLE: begin
          if (bus.i_sof) begin
            if (!full[wbank]) begin
              wr_en    = 1'b1;
              wr_laddr = '0;
            end else begin
              w_drop = 1'b1;
            end
          end
        end
        W_ACTIVE: begin
          wr_en = 1'b1;
          // An early SOF abandons the partial frame and restarts the same bank.
          if (bus.i_sof) begin
            wr_laddr = '0;
            w_drop   = 1'b1;
          end else begin
            w_last = (waddr == LAST);
          end
        end
      endcase
    end
    rd_issue = !i_rst && (rstate == R_ACTIVE) && bus.i_req && !bus.i_almostfull;
    rd_last  = rd_issue && (raddr == LAST);
    set_mask = {w_last && wbank, w_last && !wbank};
    clr_mask = {rd_last && rbank, rd_last && !rbank};
  end

  // p1: BRAM write port and registered read port
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[phys_addr(wbank, wr_laddr)] <= bus.i_data;
    if (rd_issue) rd_data_p1 <= mem[phys_addr(rbank, raddr)];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wstate    <= W_IDLE;
      rstate    <= R_IDLE;
      waddr     <= '0;
      raddr     <= '0;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      full      <= 2'b00;
      drop_q    <= 1'b0;
      rd_vld_p1 <= 1'b0;
      wr_p2     <= 1'b0;
      wdata_p2  <= '0;
    end else begin
      drop_q <= w_drop;
      full   <= (full | set_mask) & ~clr_mask;
      case (wstate)
        W_IDLE: begin
          if (wr_en) begin
            waddr  <= AW'(1);
            wstate <= W_ACTIVE;
          end
        end
        W_ACTIVE: begin
          if (bus.i_valid) begin
            if (bus.i_sof) begin
              waddr <= AW'(1);
            end else if (w_last) begin
              waddr  <= '0;
              wbank  <= ~wbank;
              wstate <= W_IDLE;
            end else begin
              waddr <= waddr + 1'b1;
            end
          end
        end
      endcase
      case (rstate)
        R_IDLE: begin
          if (full[rbank]) begin
            raddr  <= '0;
            rstate <= R_ACTIVE;
          end
        end
        R_ACTIVE: begin
          if (rd_issue) begin
            if (rd_last) begin
              raddr  <= '0;
              rbank  <= ~rbank;
              rstate <= R_IDLE;
            end else begin
              raddr <= raddr + 1'b1;
            end
          end
        end
      endcase
      // p2: FIFO write strobe; data holds between strobes
      rd_vld_p1 <= rd_issue;
      wr_p2     <= rd_vld_p1;
      if (rd_vld_p1) wdata_p2 <= rd_data_p1;
    end
  end

  assign bus.o_wr         = wr_p2;
  assign bus.o_wdata      = wdata_p2;
  assign bus.o_full       = full;
  assign bus.o_rbank      = rbank;
  assign bus.o_frame_drop = drop_q;
endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Randomized bench for frame_buffer_ctrl with a frame-level reference model:
// accepted frames queue up as expected output, and bank occupancy decides drops.
module tb_frame_buffer_ctrl;
  localparam int DW = 12;
  localparam int FP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_buffer_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  frame_buffer_ctrl #(.DATA_WIDTH(DW), .FRAME_PIXELS(FP)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rx_q[$];
  int rx_total = 0;
  int frames_done = 0;
  int drops_seen = 0;
  int drops_exp = 0;
  int af_viol = 0;
  bit af_last = 1'b0;
  bit af_prev = 1'b0;
  bit partial_open = 1'b0;
  bit rnd_rd = 1'b0;

  always @(posedge clk) begin
    af_prev = af_last;
    af_last = bus.i_almostfull;
  end

  always @(negedge clk) begin
    if (bus.o_wr === 1'b1) begin
      rx_q.push_back(bus.o_wdata);
      rx_total++;
      if (af_prev) af_viol++;
    end
    if (bus.o_frame_drop === 1'b1) drops_seen++;
  end

  task automatic drive(input bit v, input bit s, input logic [DW-1:0] d);
    @(negedge clk);
    bus.i_valid = v;
    bus.i_sof   = s;
    bus.i_data  = d;
    if (rnd_rd) begin
      bus.i_req        = ($urandom_range(0, 3) != 0);
      bus.i_almostfull = ($urandom_range(0, 4) == 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, DW'($urandom));
  endtask

  task automatic rand_frame(output logic [DW-1:0] px[$], input int n);
    px.delete();
    for (int i = 0; i < n; i++) px.push_back(DW'($urandom));
  endtask

  // Frame-level model: a frame is dropped when both banks hold unread frames.
  task automatic send_frame(input logic [DW-1:0] px[$], input int gap_max);
    bit dropped = 1'b0;
    if (partial_open) begin
      drops_exp++;
      partial_open = 1'b0;
    end else if (frames_done - rx_total / FP >= 2) begin
      dropped = 1'b1;
      drops_exp++;
    end
    for (int i = 0; i < px.size(); i++) begin
      int g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) drive(1'b0, 1'b0, DW'($urandom));
      drive(1'b1, i == 0, px[i]);
    end
    if (!dropped) begin
      foreach (px[i]) exp_q.push_back(px[i]);
      frames_done++;
    end
  endtask

  task automatic send_partial(input logic [DW-1:0] px[$]);
    for (int i = 0; i < px.size(); i++) drive(1'b1, i == 0, px[i]);
    partial_open = 1'b1;
  endtask

  task automatic check_output(input string name, input int max_cyc);
    int cyc = 0;
    int n;
    while (rx_q.size() < exp_q.size() && cyc < max_cyc) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (cyc >= max_cyc) begin
      total++; bad++;
      $display("FAIL %s_timeout got=%0d pixels required=%0d", name, rx_q.size(), exp_q.size());
    end
    idle(4);
    total++;
    if (rx_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL %s_count got=%0d required=%0d", name, rx_q.size(), exp_q.size());
    end
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s_pixel[%0d] got=%h required=%h", name, i, rx_q[i], exp_q[i]);
      end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_val(input string name, input logic [1:0] got, input logic [1:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%b required=%b", name, got, req);
    end
  endtask

  task automatic test_reset(input string name, input bit keep_valid);
    @(negedge clk);
    rst = 1'b1;
    bus.i_req = 1'b0;
    bus.i_almostfull = 1'b0;
    bus.i_valid = keep_valid;
    bus.i_sof = 1'b0;
    bus.i_data = DW'($urandom);
    @(negedge clk);
    total++;
    if (bus.o_wr !== 1'b0) begin bad++; $display("FAIL %s_o_wr got=%b required=0", name, bus.o_wr); end
    total++;
    if (bus.o_wdata !== '0) begin bad++; $display("FAIL %s_o_wdata got=%h required=0", name, bus.o_wdata); end
    total++;
    if (bus.o_frame_drop !== 1'b0) begin bad++; $display("FAIL %s_o_frame_drop got=%b required=0", name, bus.o_frame_drop); end
    total++;
    if (bus.o_full !== 2'b00) begin bad++; $display("FAIL %s_o_full got=%b required=00", name, bus.o_full); end
    total++;
    if (bus.o_rbank !== 1'b0) begin bad++; $display("FAIL %s_o_rbank got=%b required=0", name, bus.o_rbank); end
    rst = 1'b0;
    bus.i_valid = 1'b0;
    exp_q.delete();
    rx_q.delete();
    rx_total = 0;
    frames_done = 0;
    partial_open = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [DW-1:0] px[$];
    for (int i = 0; i < FP; i++) px.push_back(DW'(i));
    bus.i_req = 1'b1;
    bus.i_almostfull = 1'b0;
    send_frame(px, 0);
    idle(1);
    check_val("single_full_set", bus.o_full, 2'b01);
    check_output("single", 100);
    check_val("single_full_clr", bus.o_full, 2'b00);
    check_val("single_rbank", {1'b0, bus.o_rbank}, 2'b01);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] px[$];
    int d_seen = drops_seen;
    int d_exp = drops_exp;
    bus.i_req = 1'b0;
    bus.i_almostfull = 1'b0;
    for (int f = 0; f < 3; f++) begin
      rand_frame(px, FP);
      send_frame(px, 0);
    end
    idle(3);
    check_val("b2b_full", bus.o_full, 2'b11);
    total++;
    if (drops_seen - d_seen !== drops_exp - d_exp) begin
      bad++;
      $display("FAIL b2b_drops got=%0d required=%0d", drops_seen - d_seen, drops_exp - d_exp);
    end
    bus.i_req = 1'b1;
    check_output("b2b", 300);
    check_val("b2b_full_after", bus.o_full, 2'b00);
  endtask

  task automatic test_early_sof();
    logic [DW-1:0] px[$];
    int d_seen = drops_seen;
    int d_exp = drops_exp;
    bus.i_req = 1'b0;
    rand_frame(px, 5);
    send_partial(px);
    rand_frame(px, FP);
    send_frame(px, 0);
    idle(3);
    total++;
    if (drops_seen - d_seen !== drops_exp - d_exp) begin
      bad++;
      $display("FAIL early_sof_drops got=%0d required=%0d", drops_seen - d_seen, drops_exp - d_exp);
    end
    bus.i_req = 1'b1;
    check_output("early_sof", 100);
  endtask

  task automatic test_almostfull();
    logic [DW-1:0] px[$];
    int v0 = af_viol;
    int cyc = 0;
    bus.i_req = 1'b0;
    bus.i_almostfull = 1'b0;
    rand_frame(px, FP);
    send_frame(px, 0);
    idle(1);
    while (rx_q.size() < FP && cyc < 300) begin
      @(negedge clk);
      bus.i_req = 1'b1;
      bus.i_almostfull = ((cyc / 3) % 2) == 1;
      cyc++;
    end
    bus.i_almostfull = 1'b0;
    idle(2);
    total++;
    if (af_viol - v0 !== 0) begin
      bad++;
      $display("FAIL af_late_write got=%0d writes required=0", af_viol - v0);
    end
    check_output("almostfull", 100);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] px[$];
    int cyc = 0;
    bus.i_req = 1'b0;
    rand_frame(px, 7);
    send_partial(px);
    test_reset("rst_mid_write", 1'b1);
    rand_frame(px, FP);
    send_frame(px, 0);
    idle(1);
    check_val("rst_w_full", bus.o_full, 2'b01);
    check_val("rst_w_rbank", {1'b0, bus.o_rbank}, 2'b00);
    bus.i_req = 1'b1;
    while (rx_q.size() < 9 && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 100) begin
      total++; bad++;
      $display("FAIL rst_mid_read_timeout got=%0d pixels required=9", rx_q.size());
    end
    test_reset("rst_mid_read", 1'b0);
    rand_frame(px, FP);
    send_frame(px, 0);
    idle(1);
    check_val("rst_r_full", bus.o_full, 2'b01);
    check_val("rst_r_rbank", {1'b0, bus.o_rbank}, 2'b00);
    bus.i_req = 1'b1;
    check_output("rst_after", 100);
  endtask

  task automatic test_random_stream();
    logic [DW-1:0] px[$];
    int d_seen = drops_seen;
    int d_exp = drops_exp;
    rnd_rd = 1'b1;
    for (int f = 0; f < 4; f++) begin
      int cyc = 0;
      while (frames_done - rx_total / FP > 1 && cyc < 400) begin
        idle(1);
        cyc++;
      end
      if (cyc >= 400) begin
        total++; bad++;
        $display("FAIL random_wait_bank got=%0d outstanding required<=1", frames_done - rx_total / FP);
      end
      rand_frame(px, FP);
      send_frame(px, 2);
    end
    rnd_rd = 1'b0;
    bus.i_req = 1'b1;
    bus.i_almostfull = 1'b0;
    check_output("random", 1000);
    total++;
    if (drops_seen - d_seen !== drops_exp - d_exp) begin
      bad++;
      $display("FAIL random_drops got=%0d required=%0d", drops_seen - d_seen, drops_exp - d_exp);
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_sof = 1'b0;
    bus.i_data = '0;
    bus.i_req = 1'b0;
    bus.i_almostfull = 1'b0;
    test_reset("init", 1'b0);
    test_single_frame();
    test_back_to_back();
    test_early_sof();
    test_almostfull();
    test_reset_mid();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
